// File: rtl/rv32i_types.sv
// rv32i_types: shared CDB payload type and CDB requester indexing
//   cdb_t         - result broadcast record (valid, preg, areg, result, jalr info)
//   NUM_CDB_REQ   - number of CDB requesters
//   cdb_req_idx_t - fixed requester order ALU=0, MUL=1, LS=2
package rv32i_types;
  localparam int NUM_CDB_REQ = 3;
  localparam int CDB_PTR_W = $clog2(NUM_CDB_REQ);
  typedef enum logic [1:0] {CDB_ALU, CDB_MUL, CDB_LS} cdb_req_idx_t;
  typedef struct packed {
    logic        cdb_valid;
    logic [5:0]  preg_index;
    logic [4:0]  areg_index;
    logic [31:0] result;
    logic        jalr_flag;
    logic [31:0] jalr_return_pc;
  } cdb_t;
endpackage

// File: rtl/cdb_arbiter_if.sv
// cdb_arbiter_if: requester/flush inputs, ready handshakes and cdb broadcast
//   master - functional units and flush source (drive requests, see ready/cdb)
//   slave  - the arbiter (drives ready, cdb and the round-robin pointer view)
interface cdb_arbiter_if;
  import rv32i_types::*;
  logic                 branch_flush;
  cdb_t                 alu_req, mul_req, ls_req;
  logic                 alu_ready, mul_ready, ls_ready;
  cdb_t                 cdb;
  logic [CDB_PTR_W-1:0] rr_ptr;
  modport master (
    output branch_flush, alu_req, mul_req, ls_req,
    input  alu_ready, mul_ready, ls_ready, cdb, rr_ptr
  );
  modport slave (
    input  branch_flush, alu_req, mul_req, ls_req,
    output alu_ready, mul_ready, ls_ready, cdb, rr_ptr
  );
endinterface

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin one-hot grant over N requesters
//   clk, rst - clock, synchronous active-low reset
//   req_i    - request vector
//   gnt_o    - one-hot grant (zero when no request)
//   ptr_o    - last winner; reset value N-1 gives index 0 highest priority
module rr_arbiter #(
  parameter int N = 3,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req_i,
  output logic [N-1:0] gnt_o,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;
  always_comb begin
    int best, win;
    best = N;
    win = 0;
    gnt_o = '0;
    // nearest requester counting from the slot after the last winner wins
    for (int j = 0; j < N; j++)
      if (req_i[j] && (j + 2 * N - int'(ptr_q) - 1) % N < best) begin
        best = (j + 2 * N - int'(ptr_q) - 1) % N;
        win = j;
      end
    for (int j = 0; j < N; j++) gnt_o[j] = (best < N) && (win == j);
    ptr_d = (best < N) ? W'(win) : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= !rst ? W'(N - 1) : ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin CDB arbiter with one skid entry per requester
//   clk, rst - clock, synchronous active-low reset
//   bus      - slave side: branch_flush, alu/mul/ls_req in; *_ready, cdb, rr_ptr out
module cdb_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_REQ = NUM_CDB_REQ
) (
  input logic          clk,
  input logic          rst,
  cdb_arbiter_if.slave bus
);
  cdb_t req [NUM_REQ];
  cdb_t cand [NUM_REQ];
  cdb_t skid_q [NUM_REQ];
  cdb_t cdb_q, cdb_d;
  logic [NUM_REQ-1:0] skid_v_q, vld, gnt, ready, acc;
  assign req[CDB_ALU] = bus.alu_req;
  assign req[CDB_MUL] = bus.mul_req;
  assign req[CDB_LS]  = bus.ls_req;
  assign bus.alu_ready = ready[CDB_ALU];
  assign bus.mul_ready = ready[CDB_MUL];
  assign bus.ls_ready  = ready[CDB_LS];
  assign bus.cdb = cdb_q;
  // a buffered result always goes ahead of the live request from the same unit
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      cand[i] = skid_v_q[i] ? skid_q[i] : req[i];
      vld[i] = cand[i].cdb_valid && !bus.branch_flush;
    end
  end
  rr_arbiter #(.N(NUM_REQ)) u_rr (
    .clk  (clk),
    .rst  (rst),
    .req_i(vld),
    .gnt_o(gnt),
    .ptr_o(bus.rr_ptr)
  );
  always_comb begin
    cdb_d = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      ready[i] = rst && (bus.branch_flush || !skid_v_q[i] || gnt[i]);
      acc[i] = req[i].cdb_valid && ready[i];
      if (gnt[i]) cdb_d = cand[i];
    end
  end
  // an accepted request lands in the skid unless it went straight to the cdb
  always_ff @(posedge clk) begin
    if (!rst || bus.branch_flush) begin
      skid_v_q <= '0;
      cdb_q <= '0;
    end else begin
      cdb_q <= cdb_d;
      for (int i = 0; i < NUM_REQ; i++) begin
        skid_v_q[i] <= gnt[i] ? skid_v_q[i] && acc[i] : skid_v_q[i] || acc[i];
        if (acc[i] && !(gnt[i] && !skid_v_q[i])) skid_q[i] <= req[i];
      end
    end
  end
endmodule
